// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
// Shares a single-port data memory between two requesters.
//   Port A : pipeline M stage (byteen / wdata already lane-aligned)
//   Port B : secondary master (bridge, DMA, ...)
// Round-robin arbitration. The winning request is latched, the memory is
// driven for WAIT_CYCLES cycles, then one ack pulse is returned together with
// the read data (reads only).
//
// Ports
//   clk, reset             : rising-edge clock, asynchronous active-low reset
//   a_req/we/addr/byteen/wdata, b_* : requester inputs, req held until ack
//   a_ack, a_rdata, b_ack, b_rdata  : completion pulse and read data
//   a_stall                : a_req & ~a_ack, freezes the pipeline
//   mem_en/we/addr/byteen/wdata, mem_rdata : memory side
// -----------------------------------------------------------------------------
module dm_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [3:0]  a_byteen,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic [31:0] a_rdata,
    output logic        a_stall,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [3:0]  b_byteen,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic [31:0] b_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic               w_grant_valid;
    logic               w_grant_b;
    logic               w_sel_we;
    logic [29:0]        w_sel_addr_hi;
    logic [3:0]         w_sel_byteen;
    logic [31:0]        w_sel_wdata;

    logic               r_last_b;   // 1: last grant went to port B
    logic               r_gnt_b;    // port owning the current access
    logic               r_we;
    logic [29:0]        r_addr_hi;
    logic [3:0]         r_byteen;
    logic [31:0]        r_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_a_rdata;
    logic [31:0]        r_b_rdata;

    // Byte-offset bits are never interpreted; lanes come from byteen only.
    logic               w_unused_addr_bits;
    assign w_unused_addr_bits = ^{a_addr[1:0], b_addr[1:0]};

    // Request mux: the selected port's fields, valid whenever a grant is made.
    always_comb begin
        w_sel_we      = w_grant_b ? b_we         : a_we;
        w_sel_addr_hi = w_grant_b ? b_addr[31:2] : a_addr[31:2];
        w_sel_byteen  = w_grant_b ? b_byteen     : a_byteen;
        w_sel_wdata   = w_grant_b ? b_wdata      : a_wdata;
    end

    // Next-state logic and round-robin grant decision.
    always_comb begin
        w_next_state  = r_state;
        w_grant_valid = 1'b0;
        w_grant_b     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (a_req && b_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_b     = ~r_last_b;
                end else if (a_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_b     = 1'b0;
                end else if (b_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_b     = 1'b1;
                end else begin
                    w_grant_valid = 1'b0;
                    w_grant_b     = 1'b0;
                end
                if (!w_grant_valid) begin
                    w_next_state = S_IDLE;
                end else if (w_sel_we && (w_sel_byteen == 4'b0000)) begin
                    // Null store: nothing to write, acknowledge directly.
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_BUSY;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latched request, wait counter, round-robin pointer and read data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_b  <= 1'b1;
            r_gnt_b   <= 1'b0;
            r_we      <= 1'b0;
            r_addr_hi <= 30'd0;
            r_byteen  <= 4'b0000;
            r_wdata   <= 32'd0;
            r_cnt     <= '0;
            r_a_rdata <= 32'd0;
            r_b_rdata <= 32'd0;
        end else if (w_grant_valid) begin
            r_last_b  <= w_grant_b;
            r_gnt_b   <= w_grant_b;
            r_we      <= w_sel_we;
            r_addr_hi <= w_sel_addr_hi;
            r_byteen  <= w_sel_we ? w_sel_byteen : 4'b1111;
            r_wdata   <= w_sel_we ? w_sel_wdata  : 32'd0;
            r_cnt     <= CNT_W'(WAIT_CYCLES - 1);
        end else if (r_state == S_BUSY) begin
            if (r_cnt == '0) begin
                // Last cycle of mem_en: mem_rdata is valid now.
                if (!r_we && r_gnt_b) begin
                    r_b_rdata <= mem_rdata;
                end else if (!r_we) begin
                    r_a_rdata <= mem_rdata;
                end
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Outputs are pure decodes of registered state, zero outside their phase.
    assign mem_en     = (r_state == S_BUSY);
    assign mem_we     = mem_en & r_we;
    assign mem_addr   = mem_en ? {r_addr_hi, 2'b00} : 32'd0;
    assign mem_byteen = mem_en ? r_byteen : 4'b0000;
    assign mem_wdata  = mem_en ? r_wdata  : 32'd0;

    assign a_ack      = (r_state == S_DONE) & ~r_gnt_b;
    assign b_ack      = (r_state == S_DONE) &  r_gnt_b;
    assign a_rdata    = r_a_rdata;
    assign b_rdata    = r_b_rdata;

    // Gated by reset so a held a_req does not stall while the block is in reset.
    assign a_stall    = reset & a_req & ~a_ack;

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port data memory between two requesters.
  - Port A is the pipeline M stage; its byteen and write data are already lane-aligned by the store-lane logic.
  - Port B is a secondary master, such as a bridge or DMA.
- Arbitrates round-robin, latches the winning request, drives the memory for a configurable number of wait cycles, and returns one ack pulse with read data.
- Port A uses a_stall to freeze the pipeline while its access is outstanding.

Parameters:
- WAIT_CYCLES, 1, cycles mem_en is held per access (legal 1..15).
- CNT_W, 4, width of the wait counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- a_req  input  1  port A request, held until a_ack
- a_we  input  1  port A write enable
- a_addr  input  32  port A byte address
- a_byteen  input  4  port A byte lanes
- a_wdata  input  32  port A write data, lane-aligned
- a_ack  output  1  port A completion pulse
- a_rdata  output  32  port A read data, valid with a_ack
- a_stall  output  1  a_req & ~a_ack (combinational)
- b_req, b_we, b_addr[31:0], b_byteen[3:0], b_wdata[31:0]  input  same meaning as port A
- b_ack  output  1  port B completion pulse
- b_rdata  output  32  port B read data, valid with b_ack
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write
- mem_addr  output  32  {addr[31:2],2'b00}
- mem_byteen  output  4  lanes to memory; 4'b1111 on reads
- mem_wdata  output  32  write data
- mem_rdata  input  32  memory read data, valid on the last cycle of mem_en

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE.
  - All outputs 0: acks, rdata, mem_* and a_stall (a_stall is 0 because a_req is ignored in reset).
  - last_grant=B, so A wins the first tie.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Only one of a_req/b_req set: grant that port.
  - Both set: grant the port != last_grant.
  - On a grant, latch we/addr/byteen/wdata and the grant id, update last_grant, and set cnt=WAIT_CYCLES-1.
  - Write with byteen==4'b0000: go straight to DONE with no mem_en (null store).
  - Otherwise go to BUSY.
  - No request: stay in IDLE, all outputs 0.
- BUSY:
  - mem_en=1 and mem_* driven from the latched copy, stable for WAIT_CYCLES cycles.
  - Decrement cnt each cycle.
  - When cnt==0: capture mem_rdata into the granted port's rdata register (reads only; writes leave rdata unchanged), then go to DONE.
- DONE:
  - Granted port's ack=1 for exactly one cycle; mem_en=0.
  - Return to IDLE.
  - A new grant can be made in the cycle after DONE, not in DONE itself.
- Latency: request seen in IDLE at cycle t gives mem_en over t+1..t+WAIT_CYCLES and ack at t+WAIT_CYCLES+1. A null store gives ack at t+1.
- rdata holds its last captured value until the next read completes on that port.
- Requests arriving while BUSY/DONE are ignored until IDLE; the requester must hold req.
- req dropped mid-transaction: the access still completes and ack still pulses.
- Back-to-back requests are not protocol errors: a requester that re-asserts req immediately after its ack gets serviced again. When the other port is also requesting, round-robin alternates grants between them.
- a/b rdata are independent registers; a grant to one port never alters the other's rdata.
- Reset asserted mid-BUSY: access aborted, mem_en drops immediately (asynchronous), no ack is issued.
- Address low bits [1:0] are not interpreted; lane selection is by byteen only.

Test Plan:
1. Single read, WAIT_CYCLES=1: a_req, a_we=0, a_addr=0x10, mem_rdata=0xDEADBEEF.
   - mem_en=1 for 1 cycle with mem_addr=0x10, mem_byteen=1111.
   - a_ack 2 cycles after the request; a_rdata=0xDEADBEEF; a_stall high for 2 cycles.
2. Byte store, WAIT_CYCLES=3: a_we=1, a_addr=0x13, a_byteen=1000, a_wdata=0xAB000000.
   - mem_en high for 3 cycles with mem_addr=0x10, mem_byteen=1000.
   - a_ack on the 4th cycle after the request.
3. Tie from reset: a_req=b_req=1 together, both held.
   - Grants in order A, B, A, B; each ack pulses one cycle; the non-granted port's stall/ack are undisturbed.
4. Null store: b_we=1, b_byteen=0000.
   - mem_en never asserts; b_ack 1 cycle after the request; b_rdata unchanged.
5. Reset mid-BUSY: drop reset during cycle 2 of a 3-cycle access.
   - mem_en=0 immediately, no ack.
   - After release, a tie grants A first.
6. req drop: a_req high 1 cycle, then low.
   - The access still completes; a_ack pulses at t+WAIT_CYCLES+1.
